// File: rtl/dmem_pkg.sv
// Shared constants and types for the multi-cycle data-memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, legality check,
// and load lane selection with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_lane_o,
    output logic        bad_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        byte_en_o    = 4'b0000;
        wdata_lane_o = wdata_i;
        bad_o        = 1'b0;
        load_data_o  = 32'd0;
        case (funct3_i)
            F3_B: begin
                byte_en_o    = 4'b0001 << addr_lo_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
                load_data_o  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_lane_o = {2{wdata_i[15:0]}};
                bad_o        = addr_lo_i[0];
                load_data_o  = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                byte_en_o    = 4'b1111;
                bad_o        = |addr_lo_i;
                load_data_o  = raw_i;
            end
            // Unsigned forms exist only for loads.
            F3_BU: begin
                bad_o        = write_i;
                load_data_o  = {24'd0, byte_sel};
            end
            F3_HU: begin
                bad_o        = write_i | addr_lo_i[0];
                load_data_o  = {16'd0, half_sel};
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller with configurable latency and core stall.
// Optional macro DMEM_ZERO_ON_RESET_EN clears every memory word during reset.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        stall_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               in_idle;
    logic [2:0]         sel_funct3;
    logic [1:0]         sel_addr_lo;
    logic               sel_write;
    logic [29:0]        word_addr;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        raw_word;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_lane;
    logic               bad;
    logic [31:0]        load_data;
    logic               commit;

    assign in_idle     = (state_q == S_IDLE);
    // Legality is judged on the live request in IDLE, on the latched one afterwards.
    assign sel_funct3  = in_idle ? funct3_i    : funct3_q;
    assign sel_addr_lo = in_idle ? addr_i[1:0] : addr_q[1:0];
    assign sel_write   = in_idle ? req_write_i : write_q;

    // DEPTH_WORDS is a power of two, so the modulo is a plain truncation (address wrap).
    assign word_addr = addr_q[31:2];
    assign word_idx  = IDX_W'(word_addr % DEPTH_WORDS);
    assign raw_word  = mem[word_idx];

    dmem_lane_align u_lane_align (
        .funct3_i     (sel_funct3),
        .addr_lo_i    (sel_addr_lo),
        .write_i      (sel_write),
        .wdata_i      (wdata_q),
        .raw_i        (raw_word),
        .byte_en_o    (byte_en),
        .wdata_lane_o (wdata_lane),
        .bad_o        (bad),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = addr_i;
                    funct3_d = funct3_i;
                    wdata_d  = wdata_i;
                    write_d  = req_write_i;
                    rdata_d  = 32'd0;
                    if (bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    rdata_d = write_q ? 32'd0 : load_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
        end
    end

    // A store lands only on the WAIT->RESP edge, so a reset in flight drops it.
    assign commit = (state_q == S_WAIT) && (cnt_q == '0) && write_q && !rst_i;

    always_ff @(posedge clk_i) begin
`ifdef DMEM_ZERO_ON_RESET_EN
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else
`endif
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
                end
            end
        end
    end

    assign req_ready_o  = in_idle;
    assign resp_valid_o = (state_q == S_RESP) || (state_q == S_ERR);
    assign misalign_o   = (state_q == S_ERR);
    assign rdata_o      = rdata_q;
    assign stall_o      = req_valid_i & ~resp_valid_o;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed plan cases plus randomized
// traffic against a byte-addressed reference memory.
module tb_data_mem_ctrl;

    localparam int DEPTH     = 256;
    localparam int LAT       = 2;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        stall_o;

    int checks;
    int errors;

    logic [7:0] mem_model [MEM_BYTES];

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_write_i  (req_write),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .rdata_o      (rdata_o),
        .misalign_o   (misalign_o),
        .stall_o      (stall_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_bad(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = access_size(f3);
        if (sz == 0) return 1'b1;
        if (w && f3[2]) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned b;
        int unsigned val;
        int sz;
        int sval;
        sz  = access_size(f3);
        b   = a % MEM_BYTES;
        val = 0;
        for (int k = 0; k < sz; k++) begin
            val = val + (int'(mem_model[b + k]) << (8 * k));
        end
        sval = int'(val);
        if (!f3[2] && sz < 4 && val >= (1 << (8 * sz - 1))) begin
            sval = int'(val) - (1 << (8 * sz));
        end
        return 32'(sval);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned b;
        b = a % MEM_BYTES;
        for (int k = 0; k < access_size(f3); k++) begin
            mem_model[b + k] = d[8*k +: 8];
        end
    endtask

    // One core-side transaction; returns response fields, cycles to resp and stall count.
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] rd, output logic mis,
                             output int cyc, output int stl);
        logic got;
        req_write = w;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        req_valid = 1'b1;
        cyc = 0;
        stl = 0;
        got = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (stall_o) stl++;
            @(posedge clk);
            #1;
            cyc++;
            if (resp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) cyc = -1;
        if (stall_o) stl++;
        rd  = rdata_o;
        mis = misalign_o;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("txn w=%0b f3=%03b addr=%08h wdata=%08h -> rdata=%08h mis=%0b cyc=%0d stall=%0d",
                 w, f3, a, d, rd, mis, cyc, stl);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3 = 3'b000;
        addr = 32'd0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++;
        if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", resp_valid_o); end
        checks++;
        if (rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%08h exp=0", rdata_o); end
        checks++;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        logic [31:0] rd;
        logic mis;
        int cyc, stl;
        logic [2:0] f3s [4];
        logic [31:0] adrs [4];
        logic [31:0] exps [4];

        do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, mis, cyc, stl);
        model_store(3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if (cyc !== LAT + 1) begin errors++; $display("FAIL sw_latency got=%0d exp=%0d", cyc, LAT + 1); end
        checks++;
        if (stl !== LAT + 1) begin errors++; $display("FAIL sw_stall got=%0d exp=%0d", stl, LAT + 1); end

        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%08h exp=DEADBEEF", rd); end
        checks++;
        if (cyc !== LAT + 1 || stl !== LAT + 1 || mis !== 1'b0) begin
            errors++; $display("FAIL lw_timing cyc=%0d stall=%0d mis=%b exp=%0d/%0d/0", cyc, stl, mis, LAT + 1, LAT + 1);
        end

        f3s[0] = 3'b000; adrs[0] = 32'h13; exps[0] = 32'hFFFFFFDE;
        f3s[1] = 3'b100; adrs[1] = 32'h13; exps[1] = 32'h000000DE;
        f3s[2] = 3'b001; adrs[2] = 32'h12; exps[2] = 32'hFFFFDEAD;
        f3s[3] = 3'b101; adrs[3] = 32'h10; exps[3] = 32'h0000BEEF;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, f3s[i], adrs[i], 32'h0, rd, mis, cyc, stl);
            checks++;
            if (rd !== exps[i]) begin errors++; $display("FAIL subword_load%0d got=%08h exp=%08h", i, rd, exps[i]); end
        end

        do_access(1'b1, 3'b000, 32'h11, 32'h12345677, rd, mis, cyc, stl);
        model_store(3'b000, 32'h11, 32'h12345677);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'hDEAD77EF) begin errors++; $display("FAIL sb_merge got=%08h exp=DEAD77EF", rd); end

        do_access(1'b1, 3'b010, 32'h20, 32'h01234567, rd, mis, cyc, stl);
        model_store(3'b010, 32'h20, 32'h01234567);
        do_access(1'b0, 3'b010, 32'h12, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (mis !== 1'b1 || rd !== 32'd0 || cyc !== 1) begin
            errors++; $display("FAIL lw_misalign mis=%b rdata=%08h cyc=%0d exp=1/0/1", mis, rd, cyc);
        end
        do_access(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, rd, mis, cyc, stl);
        checks++;
        if (mis !== 1'b1 || rd !== 32'd0 || cyc !== 1) begin
            errors++; $display("FAIL sh_misalign mis=%b rdata=%08h cyc=%0d exp=1/0/1", mis, rd, cyc);
        end
        do_access(1'b0, 3'b010, 32'h20, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'h01234567) begin errors++; $display("FAIL misalign_no_effect got=%08h exp=01234567", rd); end

        do_access(1'b1, 3'b010, 32'h3FC, 32'hAAAA5555, rd, mis, cyc, stl);
        model_store(3'b010, 32'h3FC, 32'hAAAA5555);
        do_access(1'b0, 3'b010, 32'h7FC, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'hAAAA5555) begin errors++; $display("FAIL wrap got=%08h exp=AAAA5555", rd); end

        do_access(1'b0, 3'b011, 32'h10, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (mis !== 1'b1 || cyc !== 1 || rd !== 32'd0) begin
            errors++; $display("FAIL illegal_f3 mis=%b cyc=%0d rdata=%08h exp=1/1/0", mis, cyc, rd);
        end
        do_access(1'b1, 3'b100, 32'h10, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (mis !== 1'b1 || cyc !== 1) begin
            errors++; $display("FAIL store_unsigned mis=%b cyc=%0d exp=1/1", mis, cyc);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] rd;
        logic mis;
        int cyc, stl;
        do_access(1'b1, 3'b010, 32'h40, 32'h0, rd, mis, cyc, stl);
        model_store(3'b010, 32'h40, 32'h0);
        req_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h40;
        wdata     = 32'h1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", req_ready_o); end
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef DMEM_ZERO_ON_RESET_EN
        for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'h00;
`endif
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || rdata_o !== 32'd0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs ready=%b resp=%b rdata=%08h mis=%b exp=1/0/0/0",
                     req_ready_o, resp_valid_o, rdata_o, misalign_o);
        end
        @(posedge clk);
        #1;
        do_access(1'b0, 3'b010, 32'h40, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL midreset_no_commit got=%08h exp=0", rd); end
`ifdef DMEM_ZERO_ON_RESET_EN
        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, cyc, stl);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL zero_on_reset got=%08h exp=0", rd); end
`endif
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic mis;
        int cyc, stl;
        logic w;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] d;
        logic exp_bad;
        logic [31:0] exp_rd;
        int exp_cyc;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_access(1'b1, 3'b010, 32'(i * 4), d, rd, mis, cyc, stl);
            model_store(3'b010, 32'(i * 4), d);
        end
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & ~32'h3FF) | 32'($urandom_range(0, 63));
            d  = $urandom;
            exp_bad = model_bad(w, f3, a);
            exp_cyc = exp_bad ? 1 : LAT + 1;
            exp_rd  = (exp_bad || w) ? 32'd0 : model_load(f3, a);
            do_access(w, f3, a, d, rd, mis, cyc, stl);
            if (w && !exp_bad) model_store(f3, a, d);
            checks++;
            if (mis !== exp_bad || cyc !== exp_cyc || stl !== exp_cyc) begin
                errors++;
                $display("FAIL rand_resp%0d mis=%b cyc=%0d stall=%0d exp=%b/%0d/%0d", n, mis, cyc, stl, exp_bad, exp_cyc, exp_cyc);
            end
            if (!w) begin
                checks++;
                if (rd !== exp_rd) begin errors++; $display("FAIL rand_load%0d got=%08h exp=%08h", n, rd, exp_rd); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            exp_rd = model_load(3'b010, 32'(i * 4));
            do_access(1'b0, 3'b010, 32'(i * 4), 32'h0, rd, mis, cyc, stl);
            checks++;
            if (rd !== exp_rd) begin errors++; $display("FAIL rand_final%0d got=%08h exp=%08h", i, rd, exp_rd); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'h00;
        test_reset;
        test_directed;
        test_reset_mid_op;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Multi-cycle data-memory controller sitting directly downstream of the single-cycle core's ALU/Decoder stage. It replaces the ideal one-cycle data memory.
- Accepts load/store requests (address = ALU result, store data = rs2, size/sign = instr[14:12]).
- Models a configurable-latency word-organised RAM.
- Stalls the core until the access completes.
- Returns a sign- or zero-extended load result to the write-back mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; address bits above log2(DEPTH_WORDS)+2 are ignored (wrap).
- LATENCY, 2, cycles spent in WAIT before commit/read; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  core requests access (MemRead|MemWrite)
- req_write_i  in  1  1 = store, 0 = load
- funct3_i  in  3  access size/sign (instr[14:12])
- addr_i  in  32  byte address
- wdata_i  in  32  store data (rs2, low-aligned)
- req_ready_o  out  1  controller can accept (state IDLE)
- resp_valid_o  out  1  one-cycle pulse: access finished
- rdata_o  out  32  extended load data, valid with resp_valid_o
- misalign_o  out  1  valid with resp_valid_o: misaligned/illegal access, no memory effect
- stall_o  out  1  core must hold PC/regfile write

Behaviour:
- Reset (rst_i high at a clock edge):
  - state := IDLE, counter := 0.
  - req_ready_o=1, resp_valid_o=0, rdata_o=0, misalign_o=0.
- FSM states IDLE, WAIT, RESP, ERR:
  - IDLE: on req_valid_i, latch addr/funct3/wdata/write.
    - Go to ERR if illegal or misaligned; otherwise go to WAIT with counter := LATENCY-1.
  - WAIT: counter decrements each cycle. When counter==0, go to RESP, and at that same edge:
    - store: write bytes under byte enables;
    - load: register extended data into rdata_o.
  - RESP: resp_valid_o=1, misalign_o=0; next state IDLE.
  - ERR: resp_valid_o=1, misalign_o=1, rdata_o=0; next state IDLE. Memory is untouched.
- Handshake and stall:
  - Accept occurs when req_valid_i & req_ready_o.
  - stall_o = req_valid_i & ~resp_valid_o (combinational). The core advances on the edge ending RESP/ERR.
  - Total latency, accept to resp_valid_o: LATENCY+1 cycles (1 cycle for errors).
  - req_valid_i is ignored outside IDLE. A request held high after RESP is re-accepted only if the core has not advanced; the core guarantees new inputs after resp.
- funct3 decode:
  - Legal: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000/001/010.
  - Everything else, including store with 1xx, is illegal and goes to ERR.
- Alignment:
  - H/HU require addr[0]==0.
  - W requires addr[1:0]==0.
  - B is always aligned.
- Store lane rules:
  - B: byte enable = 1<<addr[1:0]; data = wdata[7:0] replicated to all lanes.
  - H: byte enable = 0011 or 1100; data = wdata[15:0] replicated.
  - W: byte enable = 1111.
- Load rules:
  - Select the byte/half lane by addr[1:0].
  - B and H sign-extend from bit 7/15; BU and HU zero-extend.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Reset mid-operation: any WAIT/RESP/ERR is aborted and a pending store is not committed, because commit happens only at the WAIT->RESP edge.
- Memory contents are not reset (see Optional Feature).

Optional Feature:
- Macro DMEM_ZERO_ON_RESET_EN.
  - Defined: every reset cycle clears all DEPTH_WORDS words to 0.
  - Undefined: memory holds prior contents across reset, and initial contents are X unless preloaded by the bench.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - state encoding typedef (IDLE/WAIT/RESP/ERR);
  - LATENCY width constant (4 bits).
- One combinational sub-module, dmem_lane_align, implements:
  - funct3 + addr[1:0] + wdata -> byte_en[3:0], lane-replicated store word, misalign/illegal flag;
  - funct3 + addr[1:0] + raw word -> extended load data.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=2) -> stall_o high 3 cycles each; rdata_o=0xDEADBEEF with resp_valid_o on the 3rd cycle after accept.
- With 0xDEADBEEF @0x10:
  - LB @0x13 -> 0xFFFFFFDE;
  - LBU @0x13 -> 0x000000DE;
  - LH @0x12 -> 0xFFFFDEAD;
  - LHU @0x10 -> 0x0000BEEF.
- SB 0x12345677 @0x11 over 0xDEADBEEF -> LW @0x10 returns 0xDEAD77EF.
- LW @0x12 and SH @0x21 -> 1-cycle response with misalign_o=1, rdata_o=0; a following LW @0x20 shows unchanged data.
- SW 0xAAAA5555 @0x3FC, then LW @0x7FC with DEPTH_WORDS=256 -> wrap, returns 0xAAAA5555. funct3=011 load -> ERR.
- Assert rst_i during WAIT of SW 0x1 @0x40 (prior value 0x0) -> outputs return to reset values next cycle; LW @0x40 -> 0x0. With DMEM_ZERO_ON_RESET_EN, any preloaded word reads 0 after reset.
